dpram_fifo_ctrl: RTL and testbench
==================================

// Module: dpram_fifo_ctrl
// PURPOSE
//  Upstream controller that turns the 16x8 dual-port RAM into a synchronous FIFO.
//  Accepts a valid/ready write stream and drives the RAM write port (we/waddr/data_in).
//  Drives the RAM read port (re/raddr) and captures data_out into a 2-entry output buffer.
//  Presents a first-word-fall-through valid/ready read stream. Sits between producer and RAM.
// PARAMETERS
//  DW     8        data width; must equal RAM data_in/data_out width
//  AW     4        RAM address width; RAM depth DEPTH = 2**AW = 16 (localparam, not overridable)
// PORTS
//  clk        in   1      single clock; all logic on posedge
//  reset      in   1      synchronous, active-high reset
//  s_valid    in   1      write request from producer
//  s_ready    out  1      controller can accept a write this cycle
//  s_data     in   DW     write data
//  m_valid    out  1      output buffer head is valid
//  m_ready    in   1      consumer accepts the head this cycle
//  m_data     out  DW     output buffer head data
//  level      out  AW+2   total words held (RAM + read in flight + output buffer), max DEPTH+2
//  ram_we     out  1      to RAM we
//  ram_waddr  out  AW     to RAM waddr
//  ram_din    out  DW     to RAM data_in
//  ram_re     out  1      to RAM re
//  ram_raddr  out  AW     to RAM raddr
//  ram_dout   in   DW     from RAM data_out; valid exactly 1 cycle after the cycle ram_re=1
// BEHAVIOUR
//  Reset (sync, active-high): wptr=rptr=0; ram_cnt=0; rd_pend=0; ob_cnt=0.
//   While reset=1: s_ready=0, ram_we=0, ram_re=0, m_valid=0, level=0.
//   Reset mid-operation: all stored words and any in-flight read are discarded.
//  Write: push = s_valid & s_ready; s_ready = (ram_cnt < DEPTH).
//   ram_we = push, ram_waddr = wptr, ram_din = s_data (combinational). wptr += 1 on push.
//  Read issue: pop = m_valid & m_ready.
//   rd = (ram_cnt != 0) & (ob_cnt + rd_pend - pop < 2).
//   ram_re = rd, ram_raddr = rptr. rptr += 1 on rd. rd_pend <= rd.
//  Capture: when rd_pend=1, ram_dout is written into the output buffer tail (same edge as any pop).
//  ram_cnt next = ram_cnt + push - rd. Simultaneous push and rd is legal.
//   rd uses the registered ram_cnt, so a word written in cycle N is readable no earlier than N+1.
//   No same-address read/write collision is possible.
//  Pointers wrap modulo DEPTH (AW-bit natural overflow). Full and empty come from ram_cnt, never from pointer compare.
//  Latency: push at cycle N gives m_valid=1 at N+3 when the FIFO is empty (N+1 rd, N+2 capture, N+3 visible).
//  Throughput: 1 word/cycle sustained in both directions.
//  Output buffer: 2-entry FIFO; m_data = head; m_valid = (ob_cnt != 0).
//   Never overflows, by construction of the rd condition.
//  level = ram_cnt + rd_pend + ob_cnt, registered view of the current state.
//  m_data/m_valid are stable while m_valid & !m_ready (AXI-style hold).
//  s_valid is not required to hold; a dropped request is simply not written.
// STRUCTURE
//  dpram_pkg: DW, AW, DEPTH localparams; typedef logic [AW-1:0] addr_t; typedef logic [DW-1:0] data_t.
//  Sub-module dpram_fifo_obuf: 2-entry output buffer.
//   Ports: clk, reset, wr_en, wr_data, rd_en, rd_data, cnt[1:0].
//  Top holds the pointers, ram_cnt, rd_pend and the rd/s_ready logic.
// TESTING
//  1 Reset: hold reset 3 cycles with s_valid=1 -> s_ready=0, ram_we=0, ram_re=0, m_valid=0, level=0.
//  2 Single word: push 8'hA5 at cycle N, m_ready=1 -> ram_we=1/waddr=0 at N, ram_re=1/raddr=0 at N+1,
//    m_valid=1 and m_data=8'hA5 at N+3.
//  3 Fill: push 0x00..0x11 (18 words) with m_ready=0 -> level reaches 18, s_ready=0 after the 18th,
//    ram_cnt=16. Drain -> order 0x00..0x11 preserved.
//  4 Wrap: 40 words of push and pop interleaved at random m_ready -> in-order data.
//    wptr/rptr wrap 15->0 at least twice; no word lost or duplicated.
//  5 Streaming: s_valid=1 and m_ready=1 continuously for 64 cycles -> after 3-cycle fill, one word out
//    per cycle, level stays constant, s_ready never drops.
//  6 Reset mid-op: level=7 and read in flight, assert reset 1 cycle -> next cycle level=0, m_valid=0.
//    Stale ram_dout is not captured; next push 8'h3C is output first.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared widths and types for the dual-port-RAM FIFO controller.
// The RAM depth is fixed by AW; all counters are sized so that a full FIFO does not overflow them.
package dpram_pkg;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;
  typedef logic [AW:0]   cnt_t;    // 0..DEPTH words held in the RAM
  typedef logic [AW+1:0] lvl_t;    // 0..DEPTH+2 words held in total
endpackage

// File: rtl/dpram_fifo_obuf.sv
// Two-entry output buffer behind the RAM read port; the head is presented first-word-fall-through.
// The caller guarantees that no write arrives while both entries are occupied.
module dpram_fifo_obuf
  import dpram_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    cnt
);
  data_t      mem_q [2];
  data_t      mem_d [2];
  logic       head_q, head_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' with every output defaulted first, so no latch is inferred.
    mem_d  = mem_q;
    head_d = head_q;
    cnt_d  = cnt_q;
    if (wr_en) mem_d[head_q ^ cnt_q[0]] = wr_data;
    if (rd_en) head_d = ~head_q;
    cnt_d = cnt_q + 2'(wr_en) - 2'(rd_en);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    if (reset) begin
      head_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      cnt_q  <= cnt_d;
    end
  end

  // NOTE: the data storage is deliberately not reset; cnt_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[head_q];
  assign cnt     = cnt_q;
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Turns a 16x8 dual-port RAM with 1-cycle read latency into a synchronous FIFO:
// valid/ready write stream in, first-word-fall-through valid/ready read stream out.
module dpram_fifo_ctrl
  import dpram_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW+1:0] level,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_din,
  output logic          ram_re,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_dout
);
  addr_t      wptr_q, wptr_d;
  addr_t      rptr_q, rptr_d;
  cnt_t       ram_cnt_q, ram_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic [1:0] ob_cnt;
  logic [2:0] ob_occ;
  logic       push, pop, rd;

  always_comb begin
    s_ready = !reset && (ram_cnt_q < cnt_t'(DEPTH));
    m_valid = !reset && (ob_cnt != 2'd0);
    push    = s_valid & s_ready;
    pop     = m_valid & m_ready;

    // Buffer slots already spoken for after this cycle's pop; a read is issued only if one stays free.
    ob_occ  = {1'b0, ob_cnt} + {2'b00, rd_pend_q} - {2'b00, pop};
    rd      = !reset && (ram_cnt_q != cnt_t'(0)) && (ob_occ < 3'd2);

    ram_we    = push;
    ram_waddr = wptr_q;
    ram_din   = s_data;
    ram_re    = rd;
    ram_raddr = rptr_q;

    wptr_d    = wptr_q + addr_t'(push);
    rptr_d    = rptr_q + addr_t'(rd);
    ram_cnt_d = ram_cnt_q + cnt_t'(push) - cnt_t'(rd);
    rd_pend_d = rd;

    level = reset ? '0 : lvl_t'(ram_cnt_q) + lvl_t'(rd_pend_q) + lvl_t'(ob_cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // A read still in flight when reset hits returns stale data; it must not land in the buffer.
  dpram_fifo_obuf u_obuf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rd_pend_q & !reset),
    .wr_data (ram_dout),
    .rd_en   (pop),
    .rd_data (m_data),
    .cnt     (ob_cnt)
  );
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural 16x8 RAM (1-cycle registered read).
// Inputs change 1 ns after posedge; outputs are sampled on the falling edge.
module tb_dpram_fifo_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid, s_ready;
  logic [7:0] s_data;
  logic       m_valid, m_ready;
  logic [7:0] m_data;
  logic [5:0] level;
  logic       ram_we, ram_re;
  logic [3:0] ram_waddr, ram_raddr;
  logic [7:0] ram_din, ram_dout;
  logic [7:0] ram_mem [16];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dpram_fifo_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .level     (level),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_din   (ram_din),
    .ram_re    (ram_re),
    .ram_raddr (ram_raddr),
    .ram_dout  (ram_dout)
  );

  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[ram_waddr] <= ram_din;
    if (ram_re) ram_dout <= ram_mem[ram_raddr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({s_ready, ram_we, ram_re, m_valid} !== 4'b0000 || level !== 6'd0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc%0d: got rdy/we/re/mv=%b%b%b%b level=%0d, want 0000 level=0",
                 c, s_ready, ram_we, ram_re, m_valid, level);
      end
      step();
    end
    reset = 1'b0; s_valid = 1'b0;
  endtask

  task automatic test_single();
    s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({s_ready, ram_we} !== 2'b11 || ram_waddr !== 4'd0 || ram_din !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_write: got rdy=%b we=%b waddr=%0d din=%h, want 1 1 0 a5",
               s_ready, ram_we, ram_waddr, ram_din);
    end
    step();
    s_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ram_re !== 1'b1 || ram_raddr !== 4'd0 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_read_issue: got re=%b raddr=%0d mv=%b, want 1 0 0", ram_re, ram_raddr, m_valid);
    end
    step();
    @(negedge clk);
    vectors++;
    if (m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early_valid: got mv=%b want 0", m_valid);
    end
    step();
    @(negedge clk);
    vectors++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_output: got mv=%b data=%h, want 1 a5", m_valid, m_data);
    end
    step();
    @(negedge clk);
    vectors++;
    if (m_valid !== 1'b0 || level !== 6'd0) begin
      miscompares++;
      $display("FAIL single_empty: got mv=%b level=%0d, want 0 0", m_valid, level);
    end
    step();
  endtask

  task automatic test_fill();
    int got;
    int cyc;
    m_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      @(negedge clk);
      vectors++;
      if (s_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL fill_accept word%0d: got s_ready=%b want 1", i, s_ready);
      end
      step();
    end
    s_data = 8'hEE;
    @(negedge clk);
    vectors++;
    if (s_ready !== 1'b0 || ram_we !== 1'b0 || level !== 6'd18) begin
      miscompares++;
      $display("FAIL fill_full: got rdy=%b we=%b level=%0d, want 0 0 18", s_ready, ram_we, level);
    end
    step();
    s_valid = 1'b0; m_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < 18 && cyc < 100) begin
      @(negedge clk);
      if (m_valid) begin
        vectors++;
        if (m_data !== 8'(got)) begin
          miscompares++;
          $display("FAIL fill_drain_order: got %h want %h", m_data, 8'(got));
        end
        got++;
      end
      step();
      cyc++;
    end
    vectors++;
    if (got != 18) begin
      miscompares++;
      $display("FAIL fill_drain_timeout: got %0d words want 18", got);
    end
    @(negedge clk);
    vectors++;
    if (level !== 6'd0 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_drained: got level=%0d mv=%b want 0 0", level, m_valid);
    end
    step();
  endtask

  task automatic test_wrap();
    logic [15:0] pat;
    int tx, rx, cyc;
    logic push_ok;
    pat = 16'b1011_0010_1110_0101;
    tx = 0; rx = 0; cyc = 0;
    while ((tx < 40 || rx < 40) && cyc < 400) begin
      s_valid = (tx < 40);
      s_data  = 8'h40 + 8'(tx);
      m_ready = pat[cyc % 16];
      @(negedge clk);
      push_ok = s_valid && s_ready;
      if (m_valid && m_ready) begin
        vectors++;
        if (m_data !== 8'h40 + 8'(rx)) begin
          miscompares++;
          $display("FAIL wrap_order: got %h want %h", m_data, 8'h40 + 8'(rx));
        end
        rx++;
      end
      step();
      if (push_ok) tx++;
      cyc++;
    end
    s_valid = 1'b0;
    vectors++;
    if (tx != 40 || rx != 40) begin
      miscompares++;
      $display("FAIL wrap_count: got tx=%0d rx=%0d want 40 40", tx, rx);
    end
    @(negedge clk);
    vectors++;
    if (level !== 6'd0) begin
      miscompares++;
      $display("FAIL wrap_level: got %0d want 0", level);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int rx, cyc;
    m_ready = 1'b1;
    for (int c = 0; c < 64; c++) begin
      s_valid = 1'b1; s_data = 8'h80 + 8'(c);
      @(negedge clk);
      vectors++;
      if (s_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_ready cyc%0d: got %b want 1", c, s_ready);
      end
      if (c >= 3) begin
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 8'h80 + 8'(c - 3) || level !== 6'd3) begin
          miscompares++;
          $display("FAIL stream_out cyc%0d: got mv=%b data=%h level=%0d, want 1 %h 3",
                   c, m_valid, m_data, level, 8'h80 + 8'(c - 3));
        end
      end
      step();
    end
    s_valid = 1'b0;
    rx = 61; cyc = 0;
    while (rx < 64 && cyc < 20) begin
      @(negedge clk);
      if (m_valid) begin
        vectors++;
        if (m_data !== 8'h80 + 8'(rx)) begin
          miscompares++;
          $display("FAIL stream_tail: got %h want %h", m_data, 8'h80 + 8'(rx));
        end
        rx++;
      end
      step();
      cyc++;
    end
    vectors++;
    if (rx != 64) begin
      miscompares++;
      $display("FAIL stream_tail_timeout: got %0d words want 64", rx);
    end
  endtask

  task automatic test_reset_midop();
    int cyc;
    logic seen;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 8'h10 + 8'(i);
      step();
    end
    s_valid = 1'b0;
    step(); step(); step();
    @(negedge clk);
    vectors++;
    if (level !== 6'd8) begin
      miscompares++;
      $display("FAIL midop_level8: got %0d want 8", level);
    end
    step();
    m_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (m_valid !== 1'b1 || m_data !== 8'h10 || ram_re !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_pop: got mv=%b data=%h re=%b, want 1 10 1", m_valid, m_data, ram_re);
    end
    step();
    m_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (level !== 6'd7) begin
      miscompares++;
      $display("FAIL midop_level7: got %0d want 7", level);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (level !== 6'd0 || m_valid !== 1'b0 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_in_reset: got level=%0d mv=%b rdy=%b want 0 0 0", level, m_valid, s_ready);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (level !== 6'd0 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_after_reset: got level=%0d mv=%b want 0 0", level, m_valid);
    end
    step();
    s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (s_ready !== 1'b1 || ram_waddr !== 4'd0) begin
      miscompares++;
      $display("FAIL midop_push: got rdy=%b waddr=%0d want 1 0", s_ready, ram_waddr);
    end
    step();
    s_valid = 1'b0;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      if (m_valid) begin
        seen = 1'b1;
        vectors++;
        if (m_data !== 8'h3C) begin
          miscompares++;
          $display("FAIL midop_first_out: got %h want 3c", m_data);
        end
      end
      step();
      cyc++;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL midop_timeout: no output within 10 cycles");
    end
    @(negedge clk);
    vectors++;
    if (level !== 6'd0 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_final_empty: got level=%0d mv=%b want 0 0", level, m_valid);
    end
    step();
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    step();
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end
endmodule
